// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture and record path.
package i2s_pkg;

  // Sample width used by the capture block and everything downstream of it.
  localparam int I2S_DATA_SIZE = 24;

  // Record controller sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } rec_state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through synchronous FIFO. The head is read combinationally
// from the storage array so a word written on one edge is visible right after.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; clear empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/i2s_record_ctrl.sv
// Record sequencer: takes samples from the I2S capture block, keeps one of
// every (decim+1), buffers them and hands them out over valid/ready.
module i2s_record_ctrl
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE   = I2S_DATA_SIZE,
  parameter int LEN_WIDTH   = 16,
  parameter int DECIM_WIDTH = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LEN_WIDTH-1:0]   rec_len,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic                   sample_ready,
  input  logic [DATA_SIZE-1:0]   sample_data,
  output logic                   out_valid,
  output logic [DATA_SIZE-1:0]   out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [LEN_WIDTH-1:0]   sample_count
);

  rec_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]   rec_len_q, rec_len_d;
  logic [DECIM_WIDTH-1:0] decim_q, decim_d;
  logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [LEN_WIDTH-1:0]   sample_count_q, sample_count_d;
  logic                   overflow_q, overflow_d;

  logic                   fifo_empty, fifo_full;
  logic [DATA_SIZE-1:0]   fifo_head;
  logic                   start_accept, len_reached, consume, keep, push, pop;

  assign start_accept = (state_q == IDLE) && start && !abort;
  assign len_reached  = (sample_count_q == rec_len_q);
  // Once the programmed length is reached no more samples are taken, even
  // during the single cycle still spent in RECORD before moving to FLUSH.
  assign consume      = (state_q == RECORD) && sample_ready && !abort && !len_reached;
  assign keep         = (dcnt_q == '0);
  assign push         = consume && keep;
  assign pop          = !fifo_empty && out_ready;

  sample_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .push      (push),
    .push_data (sample_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (rec_len == '0) ? DONE : RECORD;
      RECORD:  if (len_reached) state_d = FLUSH;
      FLUSH:   if (fifo_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next-state: latch on start, count and decimate while recording.
  always_comb begin
    rec_len_d      = rec_len_q;
    decim_d        = decim_q;
    dcnt_d         = dcnt_q;
    sample_count_d = sample_count_q;
    overflow_d     = overflow_q;
    if (start_accept) begin
      rec_len_d      = rec_len;
      decim_d        = decim;
      dcnt_d         = '0;
      sample_count_d = '0;
      overflow_d     = 1'b0;
    end else if (consume) begin
      sample_count_d = (sample_count_q == '1) ? sample_count_q : sample_count_q + 1'b1;
      if (keep) begin
        dcnt_d = decim_q;
        // A kept sample with nowhere to go is lost; remember that it happened.
        if (fifo_full && !pop) overflow_d = 1'b1;
      end else begin
        dcnt_d = dcnt_q - 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_len_q      <= '0;
      decim_q        <= '0;
      dcnt_q         <= '0;
      sample_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      rec_len_q      <= rec_len_d;
      decim_q        <= decim_d;
      dcnt_q         <= dcnt_d;
      sample_count_q <= sample_count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign out_valid    = !fifo_empty;
  // Stale storage is never exposed: the data bus reads zero whenever empty.
  assign out_data     = fifo_empty ? '0 : fifo_head;
  assign overflow     = overflow_q;
  assign sample_count = sample_count_q;

endmodule

// File: doc/i2s_record_ctrl.md
Name: i2s_record_ctrl

Overview:
- Sequences audio capture from the I2S microphone front end.
- Accepts start/abort commands and records a programmed number of samples, optionally decimated.
- Buffers the kept samples in a small FIFO and hands them to a downstream consumer over a valid/ready interface.
- Sits between the I2S capture block (sample pulse + data) and the storage or transmit path (SPI/UART/memory writer).

Parameters:
- DATA_SIZE, 24, width of one audio sample.
- LEN_WIDTH, 16, width of record-length and sample counters.
- DECIM_WIDTH, 4, width of decimation factor; keep 1 of every (decim+1) samples.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- start  in  1  begin recording; honoured only in IDLE
- abort  in  1  cancel recording from any state
- rec_len  in  LEN_WIDTH  number of input samples to record; latched on accepted start
- decim  in  DECIM_WIDTH  decimation factor; latched on accepted start
- sample_ready  in  1  one-cycle pulse from capture block: sample_data is valid
- sample_data  in  DATA_SIZE  captured sample
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_SIZE  FIFO head
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at normal completion
- overflow  out  1  sticky: a kept sample was dropped (FIFO full)
- sample_count  out  LEN_WIDTH  input samples consumed in the current/last record

Behaviour:
- Reset values: state IDLE; all outputs 0; FIFO empty; latched registers 0.
- States: IDLE, RECORD, FLUSH, DONE.
- IDLE -> RECORD on start:
  - Latch rec_len and decim.
  - Clear sample_count, overflow and the decimation counter (dcnt = 0).
  - If rec_len == 0, go IDLE -> DONE instead (done pulses next cycle, no samples consumed).
- RECORD, on each sample_ready pulse:
  - sample_count increments.
  - If dcnt == 0, the sample is kept and dcnt reloads with the latched decim; otherwise it is discarded and dcnt decrements.
  - A kept sample is pushed if the FIFO has room. If the FIFO is full and no pop happens that cycle, the sample is dropped, overflow is set, and the sample still counts.
  - Push and pop in the same cycle while full is allowed; count is unchanged.
- RECORD -> FLUSH in the cycle after sample_count reaches the latched rec_len. No further samples are consumed; sample_ready is ignored outside RECORD.
- FLUSH -> DONE when the FIFO is empty (out_valid == 0).
- DONE: done = 1 for exactly one cycle, then IDLE.
- abort has priority over every transition in every state:
  - Clears the FIFO immediately and goes to IDLE next cycle.
  - No done pulse; overflow and sample_count hold their values.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins and the state stays IDLE.
- FIFO latency:
  - A sample pushed on cycle N appears on out_valid/out_data at cycle N+1.
  - out_data holds stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
- sample_count saturates at 2^LEN_WIDTH-1 (unreachable under normal use).
- rst_n asserted mid-record returns all state to reset values on the next clk edge.

Decomposition:
- Shared package i2s_pkg holds:
  - typedef enum logic [1:0] rec_state_t {IDLE, RECORD, FLUSH, DONE}
  - default DATA_SIZE constant, shared with the capture block.
- Sub-module sample_fifo: synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst_n, clear, push, push_data, pop, head, empty, full.
  - Behaviour: first-word fall-through; push-when-full-with-pop allowed.
- The controller instantiates one sample_fifo.

Test Plan:
- rec_len=8, decim=0, out_ready=1, pulses every 64 cycles with data 0x000001..0x000008 -> out_data sequence 1..8; done pulses once after the 8th sample drains; sample_count=8; overflow=0.
- rec_len=12, decim=2, data 1..12 -> outputs 1,4,7,10 only; done once; sample_count=12.
- FIFO_DEPTH=4, rec_len=6, out_ready=0, pulses every 4 cycles -> samples 1..4 buffered and 5,6 dropped; overflow=1. State holds in FLUSH until out_ready=1, then pops 1..4 and pulses done.
- abort after the 3rd of rec_len=10 with 2 entries buffered -> out_valid=0 next cycle; busy=0; no done; sample_count=3; a subsequent start runs cleanly.
- start with rec_len=0 -> busy for 1 cycle, done pulse, no FIFO activity.
- start during RECORD ignored. Same-cycle push/pop at full: count unchanged, no overflow. rst_n low mid-record -> all outputs 0 next cycle.
